// File: rtl/gpr_writeback_merge.sv
// Writeback FIFO and partial-width merge feeding the general-purpose register file.
// Optional `GPR_WRITEBACK_COMMIT_COUNT_EN adds a free-running commit_count output.
module gpr_writeback_merge #(
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_size,
  input  logic [2:0]       req_index,
  input  logic [31:0]      req_data,
  input  logic             commit_stall,
  input  logic             flush,
  input  logic [7:0][31:0] reg_value,
  output logic             write_enable,
  output logic [2:0]       write_index,
  output logic [31:0]      write_data,
  output logic             empty,
`ifdef GPR_WRITEBACK_COMMIT_COUNT_EN
  output logic [31:0]      commit_count,
`endif
  output logic             illegal_size
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_WORD    = 2'b01;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  logic [1:0]       size_mem  [DEPTH];
  logic [2:0]       index_mem [DEPTH];
  logic [31:0]      data_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic        accept;
  logic        push;
  logic        vld_p0;
  logic [1:0]  size_p0;
  logic [2:0]  index_p0;
  logic [31:0] data_p0;
  logic [2:0]  target_p0;
  logic [31:0] base_p0;
  logic [31:0] merged_p0;

  // AH/CH/DH/BH (byte, index 4-7) alias the high byte of registers 0-3.
  function automatic logic [2:0] target_of(input logic [1:0] size, input logic [2:0] index);
    if (size == SZ_BYTE && index[2])
      return {1'b0, index[1:0]};
    return index;
  endfunction

  function automatic logic [31:0] merge_data(input logic [1:0] size, input logic [2:0] index,
                                             input logic [31:0] base, input logic [31:0] data);
    case (size)
      SZ_BYTE: begin
        if (index[2])
          return {base[31:16], data[7:0], base[7:0]};
        return {base[31:8], data[7:0]};
      end
      SZ_WORD: return {base[31:16], data[15:0]};
      default: return data;
    endcase
  endfunction

  assign req_ready = (count != FULL_CNT) && !flush;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_size != SZ_ILLEGAL);
  assign vld_p0    = (count != '0) && !commit_stall && !flush;
  assign empty     = (count == '0) && !write_enable;

  always_ff @(posedge clock) begin
    if (push) begin
      size_mem[wr_ptr]  <= req_size;
      index_mem[wr_ptr] <= req_index;
      data_mem[wr_ptr]  <= req_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (vld_p0)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !vld_p0)
        count <= count + 1'b1;
      else if (!push && vld_p0)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      illegal_size <= 1'b0;
    else if (accept && req_size == SZ_ILLEGAL)
      illegal_size <= 1'b1;
  end

  // p0: FIFO head, merged against the in-flight write when it targets the same register
  assign size_p0   = size_mem[rd_ptr];
  assign index_p0  = index_mem[rd_ptr];
  assign data_p0   = data_mem[rd_ptr];
  assign target_p0 = target_of(size_p0, index_p0);
  assign base_p0   = (write_enable && write_index == target_p0) ? write_data : reg_value[target_p0];
  assign merged_p0 = merge_data(size_p0, index_p0, base_p0, data_p0);

  // p1: registered write toward the register file
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= vld_p0;
      if (vld_p0) begin
        write_index <= target_p0;
        write_data  <= merged_p0;
      end
    end
  end

`ifdef GPR_WRITEBACK_COMMIT_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      commit_count <= '0;
    else if (write_enable)
      commit_count <= commit_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_gpr_writeback_merge.sv
// Randomized bench for gpr_writeback_merge against a queue-based reference model.
module tb_gpr_writeback_merge;

  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_size;
  logic [2:0]       req_index;
  logic [31:0]      req_data;
  logic             commit_stall;
  logic             flush;
  logic [7:0][31:0] rf;
  logic             write_enable;
  logic [2:0]       write_index;
  logic [31:0]      write_data;
  logic             empty;
  logic             illegal_size;
`ifdef GPR_WRITEBACK_COMMIT_COUNT_EN
  logic [31:0]      commit_count;
`endif

  gpr_writeback_merge #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_size(req_size),
    .req_index(req_index),
    .req_data(req_data),
    .commit_stall(commit_stall),
    .flush(flush),
    .reg_value(rf),
    .write_enable(write_enable),
    .write_index(write_index),
    .write_data(write_data),
    .empty(empty),
`ifdef GPR_WRITEBACK_COMMIT_COUNT_EN
    .commit_count(commit_count),
`endif
    .illegal_size(illegal_size)
  );

  always #5 clock = ~clock;

  // Register file environment: preload port for the bench, otherwise lands DUT writes.
  logic        pl_en = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  always @(posedge clock) begin
    if (pl_en)
      rf[pl_idx] <= pl_val;
    else if (write_enable)
      rf[write_index] <= write_data;
  end

  typedef struct {
    logic [1:0]  sz;
    logic [2:0]  idx;
    logic [31:0] d;
  } req_t;

  req_t        q[$];
  logic [31:0] model_reg [8];
  logic        exp_we;
  logic [2:0]  exp_idx;
  logic [31:0] exp_data;
  logic        exp_ill;
  logic [31:0] exp_cc;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] base, input req_t r);
    case (r.sz)
      2'd0: begin
        if (r.idx >= 3'd4)
          return (base & 32'hFFFF00FF) | ({24'd0, r.d[7:0]} << 8);
        return (base & 32'hFFFFFF00) | {24'd0, r.d[7:0]};
      end
      2'd1:    return (base & 32'hFFFF0000) | (r.d & 32'h0000FFFF);
      default: return r.d;
    endcase
  endfunction

  task automatic preload(input logic [2:0] idx, input logic [31:0] val);
    pl_en = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clock);
    #1;
    pl_en = 1'b0;
    model_reg[idx] = val;
  endtask

  // One clock cycle: drive inputs, predict, then check the state after the edge.
  task automatic step(input logic v, input logic [1:0] sz, input logic [2:0] idx,
                      input logic [31:0] d, input logic st, input logic fl);
    logic  exp_ready;
    req_t  r;
    logic [2:0] tgt;
    req_valid = v;
    req_size = sz;
    req_index = idx;
    req_data = d;
    commit_stall = st;
    flush = fl;
    #1;
    exp_ready = (q.size() < DEPTH) && !fl;
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    exp_we = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && !st) begin
        r = q.pop_front();
        tgt = (r.sz == 2'd0 && r.idx >= 3'd4) ? r.idx - 3'd4 : r.idx;
        exp_we = 1'b1;
        exp_idx = tgt;
        exp_data = ref_merge(model_reg[tgt], r);
        model_reg[tgt] = exp_data;
      end
      if (v && exp_ready) begin
        if (sz == 2'd3) begin
          exp_ill = 1'b1;
        end else begin
          r.sz = sz;
          r.idx = idx;
          r.d = d;
          q.push_back(r);
        end
      end
    end
    @(posedge clock);
    #1;
    if (exp_we)
      exp_cc = exp_cc + 32'd1;
    check("write_enable", {31'd0, write_enable}, {31'd0, exp_we});
    if (exp_we) begin
      check("write_index", {29'd0, write_index}, {29'd0, exp_idx});
      check("write_data", write_data, exp_data);
    end
    check("empty", {31'd0, empty}, {31'd0, (q.size() == 0) && !exp_we});
    check("illegal_size", {31'd0, illegal_size}, {31'd0, exp_ill});
`ifdef GPR_WRITEBACK_COMMIT_COUNT_EN
    check("commit_count", commit_count, exp_cc);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 2'd0, 3'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic reset_checks();
    check("rst_write_enable", {31'd0, write_enable}, 32'd0);
    check("rst_write_index", {29'd0, write_index}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_illegal_size", {31'd0, illegal_size}, 32'd0);
`ifdef GPR_WRITEBACK_COMMIT_COUNT_EN
    check("rst_commit_count", commit_count, 32'd0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_size = 2'd0;
    req_index = 3'd0;
    req_data = 32'd0;
    commit_stall = 1'b0;
    flush = 1'b0;
    exp_we = 1'b0;
    exp_idx = '0;
    exp_data = '0;
    exp_ill = 1'b0;
    exp_cc = '0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++)
      preload(3'(i), $urandom);
    reset_checks();
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Single dword write: pulse after edge N+1, register landed by edge N+2.
    step(1'b1, 2'd2, 3'd0, 32'h12345678, 1'b0, 1'b0);
    idle(2);
    check("tp_dword_rf0", rf[0], 32'h12345678);

    // AH merge into a known register value.
    preload(3'd0, 32'hAABBCCDD);
    step(1'b1, 2'd0, 3'd4, 32'h00000011, 1'b0, 1'b0);
    idle(2);
    check("tp_ah_rf0", rf[0], 32'hAABB11DD);

    // Back-to-back partial writes to ECX exercise the bypass path.
    preload(3'd1, 32'h00000000);
    step(1'b1, 2'd0, 3'd1, 32'hFFFFFF55, 1'b0, 1'b0);
    step(1'b1, 2'd1, 3'd1, 32'hFFFF7788, 1'b0, 1'b0);
    step(1'b1, 2'd0, 3'd5, 32'hFFFFFF99, 1'b0, 1'b0);
    idle(3);
    check("tp_bypass_rf1", rf[1], 32'h00009988);

    // Fill under stall; fifth request must see req_ready low.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 2'd2, 3'(i + 2), $urandom, 1'b1, 1'b0);
    step(1'b1, 2'd2, 3'd7, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(DEPTH + 2);

    // Flush with concurrent request.
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd1, 3'(i), $urandom, 1'b1, 1'b0);
    step(1'b1, 2'd2, 3'd3, 32'h0BADF00D, 1'b0, 1'b1);
    idle(3);

    // Illegal size: handshake completes, nothing written, flag sticks.
    step(1'b1, 2'd3, 3'd2, 32'hCAFEF00D, 1'b0, 1'b0);
    idle(3);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           3'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    idle(DEPTH + 2);

    // Reset with buffered entries and no write in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, 2'd2, 3'(i), $urandom, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    reset_checks();
    q.delete();
    exp_ill = 1'b0;
    exp_cc = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_writeback_merge.md
Name: gpr_writeback_merge

Overview:
- Writeback stage directly upstream of general_propose_register: sole driver of its write_enable/write_index/write_data.
- Buffers 8/16/32-bit writeback requests from the execute stage in a small FIFO and merges partial-width data into the current 32-bit register value (AH/AL/AX semantics: untouched bits preserved).
- Emits one full 32-bit register write per cycle, with bypass for back-to-back writes to the same register.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  writeback request valid.
- req_ready  output  1  request accepted on edge when req_valid && req_ready.
- req_size  input  2  00 byte, 01 word, 10 dword, 11 illegal.
- req_index  input  3  x86 register encoding; for byte: 0-3 AL,CL,DL,BL, 4-7 AH,CH,DH,BH.
- req_data  input  32  low-aligned data; bits above size ignored.
- commit_stall  input  1  hold FIFO head; no pop this cycle.
- flush  input  1  synchronous discard of all buffered requests.
- reg_value  input  32x8  current register contents, from the register file's 32-bit read array.
- write_enable  output  1  to register file.
- write_index  output  3  to register file.
- write_data  output  32  to register file, full merged value.
- empty  output  1  FIFO empty and no write in flight.
- illegal_size  output  1  sticky error flag.

Behaviour:
- Reset (async):
  - FIFO pointers and count cleared.
  - write_enable=0, write_index=0, write_data=0.
  - illegal_size=0.
  - empty=1.
  - req_ready=1 once reset deasserts.
- Push:
  - req_ready = !full && !flush; no same-cycle pass-through when full.
  - Each entry stores {size, index, data}.
- Illegal size:
  - req_size=11 is accepted (handshake completes) but not enqueued.
  - Sets illegal_size, which holds until reset.
- Pop: occurs when !empty_fifo && !commit_stall && !flush.
- Target register selection:
  - byte with index 4-7 targets register index-4, high byte.
  - all other requests target register index.
- Merge base:
  - If write_enable && write_index == target, base = write_data (bypass of the write not yet landed).
  - Otherwise base = reg_value[target].
- Merge rules:
  - byte low: base[31:8] ++ data[7:0].
  - byte high: base[31:16] ++ data[7:0] ++ base[7:0].
  - word: base[31:16] ++ data[15:0].
  - dword: data[31:0].
- Output registration:
  - Merged value, target and enable are registered.
  - write_enable is high for exactly one cycle per popped entry.
  - write_enable is 0 in any cycle with no pop.
- Latency and throughput:
  - Request accepted at edge N → write_enable high after edge N+1 → register file updated at edge N+2.
  - Sustained throughput one request per cycle.
- Full/empty:
  - Count is 0..DEPTH; pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- Flush:
  - Empties the FIFO at the next edge.
  - Forces write_enable=0 at that edge.
  - Blocks push that cycle; flush has priority over push, pop and stall.
- commit_stall: holds the FIFO head and forces write_enable=0 next cycle; push still allowed.
- empty = (count==0) && !write_enable.
- Reset mid-operation: all buffered requests discarded; no write issued after reset.

Optional Feature:
- Macro GPR_WRITEBACK_COMMIT_COUNT_EN.
- Defined:
  - Adds output commit_count, 32 bits, reset 0.
  - Increments by 1 on every cycle write_enable=1; wraps at 2^32.
  - Not cleared by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then push dword idx0 data 0x12345678 → write_enable pulse, write_index=0, write_data=0x12345678 two edges after accept; empty returns 1.
- Preload reg0=0xAABBCCDD; push byte idx4 data 0x11 → write_data=0xAABB11DD, write_index=0.
- Back-to-back to reg1 (reg_value=0): byte idx1 0x55, then word idx1 0x7788, then byte idx5 0x99, pushed consecutively → writes 0x00000055, 0x00007788, 0x00009988 (bypass exercised).
- Hold commit_stall, push DEPTH=4 entries → req_ready=0 on 5th.
  - Release stall → four consecutive write pulses in order.
  - req_ready re-asserts after first pop.
- Push 3 entries, assert flush for one cycle → no write_enable afterwards; empty=1.
  - Flush with concurrent req_valid → req_ready=0.
- Push size=11 → handshake completes, no write issued, illegal_size=1 until reset.
  - With GPR_WRITEBACK_COMMIT_COUNT_EN defined, commit_count unchanged by it.
